in_channel_arbiter: RTL and testbench

- Shared input channel for program engines that execute `in` and `inSize` instructions.
- Buffers words from a loader in a circular FIFO.
- Arbitrates read (`in`) and size-query (`inSize`) requests from NReq engines, round-robin.
- Returns each response one cycle after grant, on a per-requester valid strobe.

---
 rtl/in_channel_arbiter.sv | 104 ++++++++++
 tb/tb_in_channel_arbiter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/in_channel_arbiter.sv
// Shared input channel: circular word FIFO filled by a loader, drained by
// round-robin arbitrated pop / size-query requests with one-cycle response.
module in_channel_arbiter #(
  parameter int Width = 12,
  parameter int Depth = 8,
  parameter int NReq  = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       load_valid,
  output logic                       load_ready,
  input  logic [Width-1:0]           load_data,
  input  logic [NReq-1:0]            req_valid,
  input  logic [NReq-1:0]            req_op,
  output logic [NReq-1:0]            req_ready,
  output logic [NReq-1:0]            rsp_valid,
  output logic [Width-1:0]           rsp_data,
  output logic                       rsp_empty,
  output logic [$clog2(Depth+1)-1:0] count
);

  localparam int CW = $clog2(Depth + 1);
  localparam int AW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int RW = (NReq > 1) ? $clog2(NReq) : 1;

  logic [Width-1:0] mem [Depth];
  logic [AW-1:0]    head;
  logic [AW-1:0]    tail;
  logic [RW-1:0]    rr_last;

  logic [NReq-1:0]  grant;
  logic [RW-1:0]    grant_idx;
  logic             grant_any;
  logic             grant_op;
  logic             load_fire;
  logic             pop_fire;
  int               idx;

  function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
    return (p == AW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  // Search starts just past the last winner; no grants while in reset.
  always_comb begin
    grant     = '0;
    grant_idx = rr_last;
    grant_any = 1'b0;
    idx       = 0;
    for (int i = 1; i <= NReq; i++) begin
      idx = (int'(rr_last) + i) % NReq;
      if (!grant_any && reset && req_valid[idx]) begin
        grant_any  = 1'b1;
        grant_idx  = RW'(idx);
        grant[idx] = 1'b1;
      end
    end
  end

  assign req_ready  = grant;
  assign grant_op   = req_op[grant_idx];
  assign load_ready = (count != CW'(Depth));
  assign load_fire  = load_valid && load_ready;
  assign pop_fire   = grant_any && !grant_op && (count != '0);

  always_ff @(posedge clock) begin
    if (load_fire) begin
      mem[tail] <= load_data;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      rr_last   <= RW'(NReq - 1);
      rsp_valid <= '0;
      rsp_data  <= '0;
      rsp_empty <= 1'b0;
    end else begin
      rsp_valid <= grant;
      if (load_fire) begin
        tail <= ptr_next(tail);
      end
      count <= count + CW'(load_fire) - CW'(pop_fire);
      if (grant_any) begin
        rr_last <= grant_idx;
        if (grant_op) begin
          // Size query reports the count before this cycle's load/pop.
          rsp_data  <= Width'(count);
          rsp_empty <= 1'b0;
        end else if (count != '0) begin
          rsp_data  <= mem[head];
          rsp_empty <= 1'b0;
          head      <= ptr_next(head);
        end else begin
          rsp_data  <= '0;
          rsp_empty <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_in_channel_arbiter.sv
// Directed bench for in_channel_arbiter: reset, size/pop sequence, round-robin,
// full boundary, wrap-around, simultaneous load/pop and mid-cycle reset.
module tb_in_channel_arbiter;

  localparam int Width = 12;
  localparam int Depth = 8;
  localparam int NReq  = 2;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             load_valid = 1'b0;
  logic             load_ready;
  logic [Width-1:0] load_data = '0;
  logic [NReq-1:0]  req_valid = '0;
  logic [NReq-1:0]  req_op = '0;
  logic [NReq-1:0]  req_ready;
  logic [NReq-1:0]  rsp_valid;
  logic [Width-1:0] rsp_data;
  logic             rsp_empty;
  logic [3:0]       count;

  int tests_run = 0;
  int tests_failed = 0;

  in_channel_arbiter #(.Width(Width), .Depth(Depth), .NReq(NReq)) dut (
    .clock      (clock),
    .reset      (reset),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .req_valid  (req_valid),
    .req_op     (req_op),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_empty  (rsp_empty),
    .count      (count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  // Called at a negedge; leaves at the following negedge.
  task automatic load_word(input logic [Width-1:0] d);
    load_valid = 1'b1;
    load_data  = d;
    #1 check("load_ready", load_ready, 1);
    @(negedge clock);
    load_valid = 1'b0;
  endtask

  task automatic request(input int r, input logic op, input int exp_data, input logic exp_empty);
    req_valid = NReq'(1) << r;
    req_op    = NReq'(op) << r;
    #1 check("req_ready", req_ready, NReq'(1) << r);
    @(negedge clock);
    req_valid = '0;
    req_op    = '0;
    check("rsp_valid", rsp_valid, NReq'(1) << r);
    check("rsp_data", rsp_data, exp_data);
    check("rsp_empty", rsp_empty, exp_empty);
  endtask

  int exp_wrap [8] = '{15, 16, 17, 20, 21, 22, 23, 24};

  initial begin
    // Reset state, with a request pending to confirm grants are blocked.
    req_valid = 2'b11;
    #2;
    check("rst_count", count, 0);
    check("rst_load_ready", load_ready, 1);
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_empty", rsp_empty, 0);
    req_valid = '0;
    @(negedge clock);
    reset = 1'b1;

    // Size queries interleaved with pops down to an empty pop.
    load_word(88);
    load_word(44);
    request(0, 1, 2, 0);
    request(0, 0, 88, 0);
    request(0, 1, 1, 0);
    request(0, 0, 44, 0);
    request(0, 1, 0, 0);
    request(0, 0, 0, 1);
    check("empty_count", count, 0);
    load_word(5);
    request(0, 0, 5, 0);

    // Round-robin between two continuous poppers.
    do_reset();
    for (int k = 1; k <= 4; k++) load_word(Width'(k));
    req_valid = 2'b11;
    req_op    = 2'b00;
    for (int k = 0; k < 4; k++) begin
      #1 check("rr_grant", req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
      @(negedge clock);
      check("rr_rsp_valid", rsp_valid, (k % 2 == 0) ? 2'b01 : 2'b10);
      check("rr_rsp_data", rsp_data, k + 1);
    end
    req_valid = '0;
    @(negedge clock);
    check("rr_idle_valid", rsp_valid, 0);
    check("rr_hold_data", rsp_data, 4);

    // Full boundary: ninth word is held off until a pop frees a slot.
    do_reset();
    for (int k = 0; k < 8; k++) load_word(Width'(100 + k));
    check("full_count", count, 8);
    check("full_load_ready", load_ready, 0);
    load_valid = 1'b1;
    load_data  = 200;
    @(negedge clock);
    check("full_held_count", count, 8);
    request(0, 0, 100, 0);
    check("full_after_pop_count", count, 7);
    check("full_after_pop_ready", load_ready, 1);
    @(negedge clock);
    load_valid = 1'b0;
    check("full_refill_count", count, 8);
    for (int k = 1; k < 8; k++) request(0, 0, 100 + k, 0);
    request(0, 0, 200, 0);

    // Wrap-around of both pointers.
    do_reset();
    for (int k = 10; k <= 17; k++) load_word(Width'(k));
    for (int k = 10; k <= 14; k++) request(0, 0, k, 0);
    for (int k = 20; k <= 24; k++) load_word(Width'(k));
    check("wrap_count", count, 8);
    for (int k = 0; k < 8; k++) request(0, 0, exp_wrap[k], 0);
    check("wrap_end_count", count, 0);

    // Simultaneous load and pop, non-empty then empty.
    do_reset();
    load_word(7);
    load_valid = 1'b1;
    load_data  = 9;
    request(0, 0, 7, 0);
    load_valid = 1'b0;
    check("sim_count", count, 1);
    request(0, 0, 9, 0);
    load_valid = 1'b1;
    load_data  = 3;
    request(0, 0, 0, 1);
    load_valid = 1'b0;
    check("sim_empty_count", count, 1);
    request(0, 0, 3, 0);

    // Reset asserted mid-cycle with a response in flight.
    do_reset();
    for (int k = 1; k <= 3; k++) load_word(Width'(k));
    req_valid = 2'b01;
    req_op    = 2'b00;
    @(posedge clock);
    #2;
    req_valid = '0;
    check("mid_rsp_before", rsp_valid, 2'b01);
    reset = 1'b0;
    #1;
    check("mid_rsp_valid", rsp_valid, 0);
    check("mid_count", count, 0);
    check("mid_load_ready", load_ready, 1);
    @(negedge clock);
    reset = 1'b1;
    req_valid = 2'b11;
    #1 check("mid_first_grant", req_ready, 2'b01);
    @(negedge clock);
    req_valid = '0;
    check("mid_lost_words", rsp_empty, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
